// File: rtl/startscene_render_if.sv
// rtl/startscene_render_if.sv - pixel-side bundle between the VGA sync/scene timer and the start-screen renderer
interface startscene_render_if;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        de;
  logic [1:0]  scene;
  logic [11:0] rgb;
  logic        de_out;
  logic [1:0]  scene_q;
  logic        frame_tick;

  modport master (
    output h_cnt, v_cnt, de, scene,
    input  rgb, de_out, scene_q, frame_tick
  );

  modport slave (
    input  h_cnt, v_cnt, de, scene,
    output rgb, de_out, scene_q, frame_tick
  );
endinterface

// File: rtl/startscene_render.sv
// rtl/startscene_render.sv - start-screen pixel generator: title bitmap, falling O-piece, 2-cycle pipeline
// Optional STARTSCENE_BORDER_EN adds a 4-pixel white frame at top priority.
module startscene_render #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int FALL_STEP = 2
) (
  input logic               clk,
  input logic               rst,
  startscene_render_if.slave vga
);

  localparam logic [63:0] TITLE_ROM = 64'hEEEE_84AA_E4AE_2EEA;
  localparam logic [9:0]  TITLE_X0  = 10'd192;
  localparam logic [9:0]  TITLE_X1  = 10'd447;
  localparam logic [9:0]  TITLE_Y0  = 10'd96;
  localparam logic [9:0]  TITLE_Y1  = 10'd159;
  localparam logic [9:0]  PIECE_X0  = 10'd304;
  localparam logic [9:0]  PIECE_X1  = 10'd335;
  localparam logic [9:0]  PIECE_H   = 10'd31;
  localparam logic [9:0]  FALL_MAX  = 10'd448;
  localparam logic [9:0]  FALL_INC  = 10'(FALL_STEP);
  localparam logic [9:0]  V_LATCH   = 10'(V_ACTIVE);
`ifdef STARTSCENE_BORDER_EN
  localparam logic [9:0]  BORDER_W  = 10'd4;
  localparam logic [9:0]  BORDER_XH = 10'(H_ACTIVE - 4);
  localparam logic [9:0]  BORDER_YH = 10'(V_ACTIVE - 4);
`endif

  // Frame state: scene and piece position only move on the first blanking line
  logic       latch;
  logic [8:0] fall_y;
  logic [1:0] scene_q;
  logic       frame_tick;
  logic [9:0] fall_sum;

  assign latch    = (vga.h_cnt == 10'd0) && (vga.v_cnt == V_LATCH);
  assign fall_sum = {1'b0, fall_y} + FALL_INC;

  always_ff @(posedge clk) begin
    if (rst) begin
      scene_q    <= 2'b10;
      fall_y     <= 9'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= latch;
      if (latch) begin
        scene_q <= vga.scene;
        if (vga.scene != scene_q)
          fall_y <= 9'd0;
        else if (fall_sum > FALL_MAX)
          fall_y <= 9'd0;
        else
          fall_y <= fall_sum[8:0];
      end
    end
  end

  // Stage 1: region hits and title ROM address
  logic [9:0] piece_top;
  logic [9:0] piece_bot;
  logic [4:0] piece_dx;
  logic [4:0] piece_dy;
  logic       title_hit;
  logic       piece_hit;
  logic       piece_edge;
  logic       border_hit;
  logic [5:0] rom_addr;

  always_comb begin
    piece_top  = {1'b0, fall_y};
    piece_bot  = piece_top + PIECE_H;
    piece_dx   = 5'(vga.h_cnt - PIECE_X0);
    piece_dy   = 5'(vga.v_cnt - piece_top);
    title_hit  = (vga.h_cnt >= TITLE_X0) && (vga.h_cnt <= TITLE_X1) &&
                 (vga.v_cnt >= TITLE_Y0) && (vga.v_cnt <= TITLE_Y1);
    piece_hit  = (vga.h_cnt >= PIECE_X0) && (vga.h_cnt <= PIECE_X1) &&
                 (vga.v_cnt >= piece_top) && (vga.v_cnt <= piece_bot);
    // One-pixel grid: piece outline on the left/top, cell dividers on each cell's last column/row
    piece_edge = (piece_dx == 5'd0) || (piece_dy == 5'd0) ||
                 (piece_dx[3:0] == 4'hF) || (piece_dy[3:0] == 4'hF);
    rom_addr   = {2'((vga.v_cnt - TITLE_Y0) >> 4), 4'((vga.h_cnt - TITLE_X0) >> 4)};
`ifdef STARTSCENE_BORDER_EN
    border_hit = (vga.h_cnt < BORDER_W) || (vga.h_cnt >= BORDER_XH) ||
                 (vga.v_cnt < BORDER_W) || (vga.v_cnt >= BORDER_YH);
`else
    border_hit = 1'b0;
`endif
  end

  logic       de_s1;
  logic       title_s1;
  logic       piece_s1;
  logic       edge_s1;
  logic       border_s1;
  logic [5:0] rom_addr_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_s1       <= 1'b0;
      title_s1    <= 1'b0;
      piece_s1    <= 1'b0;
      edge_s1     <= 1'b0;
      border_s1   <= 1'b0;
      rom_addr_s1 <= 6'd0;
    end else begin
      de_s1       <= vga.de;
      title_s1    <= title_hit;
      piece_s1    <= piece_hit;
      edge_s1     <= piece_edge;
      border_s1   <= border_hit;
      rom_addr_s1 <= rom_addr;
    end
  end

  // Stage 2: ROM lookup, palette and priority mux
  logic [11:0] palette;
  logic        rom_bit;
  logic [11:0] rgb_next;

  always_comb begin
    rom_bit = TITLE_ROM[6'd63 - rom_addr_s1];
    case (scene_q)
      2'd0:    palette = 12'hF00;
      2'd1:    palette = 12'h0F0;
      2'd2:    palette = 12'h00F;
      default: palette = 12'hFF0;
    endcase
    rgb_next = 12'h000;
    if (!de_s1)
      rgb_next = 12'h000;
    else if (border_s1)
      rgb_next = 12'hFFF;
    else if (piece_s1)
      rgb_next = edge_s1 ? 12'h888 : 12'hFFF;
    else if (title_s1 && rom_bit)
      rgb_next = palette;
  end

  logic [11:0] rgb_r;
  logic        de_out_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r    <= 12'h000;
      de_out_r <= 1'b0;
    end else begin
      rgb_r    <= rgb_next;
      de_out_r <= de_s1;
    end
  end

  assign vga.rgb        = rgb_r;
  assign vga.de_out     = de_out_r;
  assign vga.scene_q    = scene_q;
  assign vga.frame_tick = frame_tick;

endmodule

// File: tb/tb_startscene_render.sv
// tb/tb_startscene_render.sv - directed self-checking bench for startscene_render
module tb_startscene_render;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  startscene_render_if bus ();

  startscene_render #(
    .H_ACTIVE (640),
    .V_ACTIVE (480),
    .FALL_STEP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(bus.slave)
  );

`ifdef STARTSCENE_BORDER_EN
  localparam logic [11:0] BORDER_EXP = 12'hFFF;
`else
  localparam logic [11:0] BORDER_EXP = 12'h000;
`endif

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [9:0] x, input logic [9:0] y, input logic d, input logic [1:0] sc);
    @(negedge clk);
    bus.h_cnt = x;
    bus.v_cnt = y;
    bus.de    = d;
    bus.scene = sc;
  endtask

  // Holds one pixel long enough for its result to reach rgb
  task automatic hold_pix(input logic [9:0] x, input logic [9:0] y, input logic d, input logic [1:0] sc);
    cyc(x, y, d, sc);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) cyc(10'd320, 10'd120, 1'b1, 2'd2);
    chk("rst_rgb",        16'(bus.rgb),        16'h000);
    chk("rst_de_out",     16'(bus.de_out),     16'h0);
    chk("rst_scene_q",    16'(bus.scene_q),    16'h2);
    chk("rst_frame_tick", 16'(bus.frame_tick), 16'h0);
    chk("rst_fall_y",     16'(dut.fall_y),     16'd0);

    rst = 1'b0;
    cyc(10'd320, 10'd120, 1'b1, 2'd2);
    chk("release_lat1",   16'(bus.rgb),        16'h000);
    cyc(10'd320, 10'd120, 1'b1, 2'd2);
    chk("release_lat2",   16'(bus.rgb),        16'h00F);
    chk("release_de_out", 16'(bus.de_out),     16'h1);

    cyc(10'd199, 10'd100, 1'b1, 2'd2);
    cyc(10'd200, 10'd100, 1'b0, 2'd2);
    cyc(10'd201, 10'd100, 1'b1, 2'd2);
    chk("blank_before",   16'(bus.rgb),        16'h00F);
    cyc(10'd240, 10'd100, 1'b1, 2'd2);
    chk("blank_rgb",      16'(bus.rgb),        16'h000);
    chk("blank_de_out",   16'(bus.de_out),     16'h0);
    cyc(10'd240, 10'd100, 1'b1, 2'd2);
    chk("blank_after",    16'(bus.rgb),        16'h00F);
    chk("blank_after_de", 16'(bus.de_out),     16'h1);
    cyc(10'd240, 10'd100, 1'b1, 2'd2);
    chk("title_unlit",    16'(bus.rgb),        16'h000);

    repeat (3) cyc(10'd0, 10'd480, 1'b0, 2'd2);
    cyc(10'd320, 10'd100, 1'b1, 2'd3);
    chk("fall_step",      16'(dut.fall_y),     16'd6);
    chk("tick_pulse",     16'(bus.frame_tick), 16'h1);
    cyc(10'd321, 10'd100, 1'b1, 2'd3);
    cyc(10'd322, 10'd100, 1'b1, 2'd3);
    chk("mid_frame_keep", 16'(bus.rgb),        16'h00F);
    chk("mid_frame_sq",   16'(bus.scene_q),    16'h2);
    cyc(10'd0, 10'd480, 1'b0, 2'd3);
    cyc(10'd100, 10'd481, 1'b0, 2'd3);
    chk("latch_tick",     16'(bus.frame_tick), 16'h1);
    chk("latch_scene_q",  16'(bus.scene_q),    16'h3);
    chk("latch_fall_rst", 16'(dut.fall_y),     16'd0);
    cyc(10'd320, 10'd100, 1'b1, 2'd3);
    chk("tick_one_cycle", 16'(bus.frame_tick), 16'h0);
    cyc(10'd320, 10'd100, 1'b1, 2'd3);
    cyc(10'd320, 10'd100, 1'b1, 2'd3);
    chk("new_palette",    16'(bus.rgb),        16'hFF0);

    cyc(10'd0, 10'd480, 1'b0, 2'd1);
    cyc(10'd10, 10'd481, 1'b0, 2'd1);
    chk("simul_scene",    16'(bus.scene_q),    16'h1);
    cyc(10'd0, 10'd480, 1'b0, 2'd3);
    cyc(10'd10, 10'd481, 1'b0, 2'd3);
    chk("back_scene3",    16'(bus.scene_q),    16'h3);

    repeat (50) cyc(10'd0, 10'd480, 1'b0, 2'd3);
    hold_pix(10'd320, 10'd105, 1'b1, 2'd3);
    chk("fall_100",       16'(dut.fall_y),     16'd100);
    chk("piece_over_title", 16'(bus.rgb),      16'hFFF);
    hold_pix(10'd304, 10'd110, 1'b1, 2'd3);
    chk("edge_over_title", 16'(bus.rgb),       16'h888);

    repeat (174) cyc(10'd0, 10'd480, 1'b0, 2'd3);
    hold_pix(10'd320, 10'd453, 1'b1, 2'd3);
    chk("fall_448",       16'(dut.fall_y),     16'd448);
    chk("piece_at_448",   16'(bus.rgb),        16'hFFF);
    hold_pix(10'd304, 10'd453, 1'b1, 2'd3);
    chk("edge_at_448",    16'(bus.rgb),        16'h888);
    cyc(10'd0, 10'd480, 1'b0, 2'd3);
    hold_pix(10'd320, 10'd5, 1'b1, 2'd3);
    chk("fall_wrap",      16'(dut.fall_y),     16'd0);
    chk("piece_wrapped",  16'(bus.rgb),        16'hFFF);
    hold_pix(10'd335, 10'd5, 1'b1, 2'd3);
    chk("piece_right_edge", 16'(bus.rgb),      16'h888);
    hold_pix(10'd336, 10'd5, 1'b1, 2'd3);
    chk("piece_outside",  16'(bus.rgb),        16'h000);

    hold_pix(10'd0, 10'd0, 1'b1, 2'd3);
    chk("border_0_0",     16'(bus.rgb),        16'(BORDER_EXP));
    hold_pix(10'd639, 10'd479, 1'b1, 2'd3);
    chk("border_639_479", 16'(bus.rgb),        16'(BORDER_EXP));
    hold_pix(10'd2, 10'd200, 1'b1, 2'd3);
    chk("border_2_200",   16'(bus.rgb),        16'(BORDER_EXP));

    hold_pix(10'd320, 10'd120, 1'b1, 2'd3);
    chk("pre_reset_px",   16'(bus.rgb),        16'hFF0);
    cyc(10'd400, 10'd300, 1'b1, 2'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rgb",    16'(bus.rgb),        16'h000);
    chk("mid_rst_de",     16'(bus.de_out),     16'h0);
    chk("mid_rst_sq",     16'(bus.scene_q),    16'h2);
    rst = 1'b0;
    hold_pix(10'd320, 10'd120, 1'b1, 2'd3);
    chk("post_rst_px",    16'(bus.rgb),        16'h00F);
    chk("post_rst_sq",    16'(bus.scene_q),    16'h2);
    cyc(10'd0, 10'd480, 1'b0, 2'd3);
    hold_pix(10'd320, 10'd120, 1'b1, 2'd3);
    chk("post_latch_sq",  16'(bus.scene_q),    16'h3);
    chk("post_latch_px",  16'(bus.rgb),        16'hFF0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
